reg_bank_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the 8-entry × 8-bit register bank. It shares the bank's single write port and bus-read path between the control unit (port 0) and the debug/loader port (port 1). Each granted request is turned into a fixed multi-cycle sequence of bank enables and selectors: read, indirect read, write, or a three-step register swap. It sits between the requesters and the bank and is the only block that drives the bank's enables, selectors and `in_data`.

---
 rtl/drfa_pkg.sv | 33 +++
 rtl/reg_bank_arbiter_if.sv | 23 ++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/reg_bank_arbiter.sv | 140 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/drfa_pkg.sv
// Shared encodings and widths for the register-bank arbiter slice.
package drfa_pkg;

  localparam int REG_W = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_READ_IND = 2'b01,
    OP_WRITE    = 2'b10,
    OP_SWAP     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_SWAP_A,
    ST_SWAP_B,
    ST_SWAP_C,
    ST_DONE
  } state_e;

  // First sequencer state for a freshly accepted operation.
  function automatic state_e entry_state(input op_e op);
    case (op)
      OP_READ, OP_READ_IND: entry_state = ST_READ;
      OP_WRITE:             entry_state = ST_WRITE;
      default:              entry_state = ST_SWAP_A;
    endcase
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side handshake bundle: two ports of request/operands plus shared result.
interface reg_bank_arbiter_if;
  import drfa_pkg::*;

  logic             req0, req1;
  op_e              op0, op1;
  logic [SEL_W-1:0] rx0, rx1, ry0, ry1;
  logic [REG_W-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic [REG_W-1:0] rdata;

  modport master (
    output req0, req1, op0, op1, rx0, rx1, ry0, ry1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata
  );

  modport slave (
    input  req0, req1, op0, op1, rx0, rx1, ry0, ry1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

  logic last;

  always_comb begin
    win = req;
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

  // Reset to port 1 so port 0 wins the first contested round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance && (|req)) begin
      last <= win[1];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Sequencer in front of the 8x8 register bank: arbitrates two requesters and
// expands each granted op into registered bank enable/select/data cycles.
module reg_bank_arbiter
  import drfa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  reg_bank_arbiter_if.slave req_if,
  output logic              bank_read_en,
  output logic              bank_write_en,
  output logic              bank_indirect_en,
  output logic [SEL_W-1:0]  bank_rx_sel,
  output logic [SEL_W-1:0]  bank_ry_sel,
  output logic [REG_W-1:0]  bank_wdata,
  input  logic [REG_W-1:0]  bank_bus_data,
  input  logic [REG_W-1:0]  bank_rx_data,
  input  logic [REG_W-1:0]  bank_ry_data
);

  state_e           state;
  logic             port_q;
  logic [SEL_W-1:0] rx_q, ry_q;
  logic [REG_W-1:0] wdata_q, tx;
  logic [1:0]       gnt_q, done_q;
  logic [REG_W-1:0] rdata_q;

  logic [1:0]       win;
  op_e              sel_op;
  logic [SEL_W-1:0] sel_rx, sel_ry;
  logic [REG_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req_if.req1, req_if.req0}),
    .advance (state == ST_IDLE),
    .win     (win)
  );

  always_comb begin
    sel_op    = win[1] ? req_if.op1    : req_if.op0;
    sel_rx    = win[1] ? req_if.rx1    : req_if.rx0;
    sel_ry    = win[1] ? req_if.ry1    : req_if.ry0;
    sel_wdata = win[1] ? req_if.wdata1 : req_if.wdata0;
  end

  // Bank controls are loaded on the edge that enters each state so they line
  // up with it; done is raised on the edge leaving DONE, i.e. in the IDLE gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      port_q           <= 1'b0;
      rx_q             <= '0;
      ry_q             <= '0;
      wdata_q          <= '0;
      tx               <= '0;
      gnt_q            <= 2'b00;
      done_q           <= 2'b00;
      rdata_q          <= '0;
      bank_read_en     <= 1'b0;
      bank_write_en    <= 1'b0;
      bank_indirect_en <= 1'b0;
      bank_rx_sel      <= '0;
      bank_ry_sel      <= '0;
      bank_wdata       <= '0;
    end else begin
      gnt_q            <= 2'b00;
      done_q           <= 2'b00;
      bank_read_en     <= 1'b0;
      bank_write_en    <= 1'b0;
      bank_indirect_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|win) begin
            port_q  <= win[1];
            rx_q    <= sel_rx;
            ry_q    <= sel_ry;
            wdata_q <= sel_wdata;
            gnt_q   <= win;
            state   <= entry_state(sel_op);
            case (sel_op)
              OP_READ, OP_READ_IND: begin
                bank_read_en     <= 1'b1;
                bank_indirect_en <= (sel_op == OP_READ_IND);
                bank_ry_sel      <= sel_ry;
              end
              OP_WRITE: begin
                bank_write_en <= 1'b1;
                bank_rx_sel   <= sel_rx;
                bank_wdata    <= sel_wdata;
              end
              OP_SWAP: begin
                bank_rx_sel <= sel_rx;
                bank_ry_sel <= sel_ry;
              end
            endcase
          end
        end
        ST_READ: begin
          rdata_q <= bank_bus_data;
          state   <= ST_DONE;
        end
        ST_WRITE: begin
          rdata_q <= wdata_q;
          state   <= ST_DONE;
        end
        // bank_wdata doubles as the ty temporary: it is written straight into rx.
        ST_SWAP_A: begin
          tx            <= bank_rx_data;
          bank_wdata    <= bank_ry_data;
          bank_write_en <= 1'b1;
          bank_rx_sel   <= rx_q;
          state         <= ST_SWAP_B;
        end
        ST_SWAP_B: begin
          bank_wdata    <= tx;
          bank_write_en <= 1'b1;
          bank_rx_sel   <= ry_q;
          state         <= ST_SWAP_C;
        end
        ST_SWAP_C: begin
          rdata_q <= tx;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= port_q ? 2'b10 : 2'b01;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_if.gnt0  = gnt_q[0];
  assign req_if.gnt1  = gnt_q[1];
  assign req_if.done0 = done_q[0];
  assign req_if.done1 = done_q[1];
  assign req_if.rdata = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural 8x8 register bank.
module tb_reg_bank_arbiter;
  import drfa_pkg::*;

  typedef struct packed {
    logic       port;
    op_e        op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [3:0] exp_lat;
    logic [1:0] exp_wr;
    logic       exp_ind;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       bank_read_en, bank_write_en, bank_indirect_en;
  logic [2:0] bank_rx_sel, bank_ry_sel;
  logic [7:0] bank_wdata;
  wire  [7:0] bank_bus_data;
  logic [7:0] bank_rx_data, bank_ry_data;
  logic [7:0] mem [8];

  int   tests = 0;
  int   fails = 0;
  vec_t vecs [14];

  reg_bank_arbiter_if rif ();

  reg_bank_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_if           (rif),
    .bank_read_en     (bank_read_en),
    .bank_write_en    (bank_write_en),
    .bank_indirect_en (bank_indirect_en),
    .bank_rx_sel      (bank_rx_sel),
    .bank_ry_sel      (bank_ry_sel),
    .bank_wdata       (bank_wdata),
    .bank_bus_data    (bank_bus_data),
    .bank_rx_data     (bank_rx_data),
    .bank_ry_data     (bank_ry_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: commits on the falling edge, bus floats when not reading.
  always @(negedge clk) if (bank_write_en) mem[bank_rx_sel] <= bank_wdata;
  assign bank_rx_data  = mem[bank_rx_sel];
  assign bank_ry_data  = mem[bank_ry_sel];
  assign bank_bus_data = bank_read_en ?
                         (bank_indirect_en ? mem[mem[bank_ry_sel][2:0]] : mem[bank_ry_sel]) : 8'bz;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_vec();
    return {3'b000, rif.gnt0, rif.gnt1, rif.done0, rif.done1, rif.rdata,
            bank_read_en, bank_write_en, bank_indirect_en, bank_rx_sel, bank_ry_sel, bank_wdata};
  endfunction

  task automatic set_port(input logic port, input logic req, input op_e op,
                          input logic [2:0] rx, input logic [2:0] ry, input logic [7:0] wd);
    if (port) begin
      rif.req1 = req; rif.op1 = op; rif.rx1 = rx; rif.ry1 = ry; rif.wdata1 = wd;
    end else begin
      rif.req0 = req; rif.op0 = op; rif.rx0 = rx; rif.ry0 = ry; rif.wdata0 = wd;
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    int   cyc;
    int   wr_cnt;
    logic ind_seen;
    logic got;
    set_port(v.port, 1'b1, v.op, v.rx, v.ry, v.wdata);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      got = v.port ? rif.gnt1 : rif.gnt0;
    end
    check_output({name, "_gnt"}, 32'(got), 32'd1);
    // Operands are scrambled after the grant; the DUT must use its latched copy.
    set_port(v.port, 1'b0, OP_SWAP, ~v.rx, ~v.ry, ~v.wdata);
    wr_cnt   = int'(bank_write_en);
    ind_seen = bank_indirect_en;
    cyc      = 0;
    while (!(rif.done0 || rif.done1) && cyc < 20) begin
      tick();
      cyc++;
      wr_cnt   += int'(bank_write_en);
      ind_seen |= bank_indirect_en;
    end
    check_output({name, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    check_output({name, "_done_port"}, {30'd0, rif.done1, rif.done0}, v.port ? 32'd2 : 32'd1);
    check_output({name, "_rdata"}, 32'(rif.rdata), 32'(v.exp_rdata));
    check_output({name, "_write_cycles"}, 32'(wr_cnt), 32'(v.exp_wr));
    check_output({name, "_indirect"}, 32'(ind_seen), 32'(v.exp_ind));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   gport [4];
    int   gcyc  [4];
    int   n, cyc, pulse_err;
    logic prev, cur, got, saw_done;
    vec_t v;

    vecs[0]  = '{1'b0, OP_WRITE,    3'd3, 3'd0, 8'h5A, 8'h5A, 4'd2, 2'd1, 1'b0};
    vecs[1]  = '{1'b0, OP_READ,     3'd0, 3'd3, 8'h00, 8'h5A, 4'd2, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, OP_WRITE,    3'd2, 3'd0, 8'h05, 8'h05, 4'd2, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, OP_WRITE,    3'd5, 3'd0, 8'hC3, 8'hC3, 4'd2, 2'd1, 1'b0};
    vecs[4]  = '{1'b1, OP_READ_IND, 3'd0, 3'd2, 8'h00, 8'hC3, 4'd2, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, OP_WRITE,    3'd1, 3'd0, 8'h11, 8'h11, 4'd2, 2'd1, 1'b0};
    vecs[6]  = '{1'b1, OP_WRITE,    3'd6, 3'd0, 8'h66, 8'h66, 4'd2, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, OP_SWAP,     3'd1, 3'd6, 8'h00, 8'h11, 4'd4, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, OP_READ,     3'd0, 3'd1, 8'h00, 8'h66, 4'd2, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, OP_READ,     3'd0, 3'd6, 8'h00, 8'h11, 4'd2, 2'd0, 1'b0};
    vecs[10] = '{1'b0, OP_WRITE,    3'd4, 3'd0, 8'h7E, 8'h7E, 4'd2, 2'd1, 1'b0};
    vecs[11] = '{1'b1, OP_SWAP,     3'd4, 3'd4, 8'h00, 8'h7E, 4'd4, 2'd2, 1'b0};
    vecs[12] = '{1'b0, OP_READ,     3'd0, 3'd4, 8'h00, 8'h7E, 4'd2, 2'd0, 1'b0};
    vecs[13] = '{1'b1, OP_READ,     3'd0, 3'd5, 8'h00, 8'hC3, 4'd2, 2'd0, 1'b0};

    set_port(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    set_port(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_output("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Both ports hold requests: grants must alternate 0,1,0,1, one per op.
    set_port(1'b0, 1'b1, OP_READ, 3'd0, 3'd0, 8'h00);
    set_port(1'b1, 1'b1, OP_READ, 3'd0, 3'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin gport[i] = -1; gcyc[i] = -100; end
    n = 0; cyc = 0; pulse_err = 0; prev = 1'b0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      cur = rif.gnt0 | rif.gnt1;
      if (rif.gnt0 && rif.gnt1) pulse_err++;
      if (cur && prev) pulse_err++;
      if (cur) begin
        gport[n] = int'(rif.gnt1);
        gcyc[n]  = cyc;
        n++;
      end
      prev = cur;
    end
    set_port(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    set_port(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    repeat (6) tick();
    check_output("rr_grant_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("rr_grant%0d_port", i), 32'(gport[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      check_output($sformatf("rr_grant%0d_spacing", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    check_output("rr_gnt_pulse", 32'(pulse_err), 32'd0);

    for (int i = 0; i < 14; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort a SWAP rx=1/ry=6 in SWAP_B; r1=0x66, r6=0x11 must survive.
    set_port(1'b0, 1'b1, OP_SWAP, 3'd1, 3'd6, 8'h00);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      got = rif.gnt0;
    end
    check_output("abort_gnt", 32'(got), 32'd1);
    set_port(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    tick();
    check_output("abort_swap_b_write_en", 32'(bank_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort_async_outputs", out_vec(), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      saw_done |= rif.done0 | rif.done1;
    end
    check_output("abort_no_done", 32'(saw_done), 32'd0);
    check_output("abort_mem_r1", 32'(mem[1]), 32'h66);
    check_output("abort_mem_r6", 32'(mem[6]), 32'h11);
    rst_n = 1'b1;
    tick();
    v = '{1'b0, OP_READ, 3'd0, 3'd1, 8'h00, 8'h66, 4'd2, 2'd0, 1'b0};
    apply_stimulus(v, "post_abort_r1");
    v = '{1'b1, OP_READ, 3'd0, 3'd6, 8'h00, 8'h11, 4'd2, 2'd0, 1'b0};
    apply_stimulus(v, "post_abort_r6");

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
